// File: rtl/reg_file_pkg.sv
// Shared defaults for the register file: geometry and the hardwired zero index.
package reg_file_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned NREGS_DEF = 8;
  localparam int unsigned AW_DEF    = 3;
  localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/reg_file_word.sv
// One architectural register: WIDTH-bit storage with write enable and async clear.
module reg_word #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] word_q;

  // Hold comes from the enable mux, never from gating the clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else if (en) begin
      word_q <= d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with r0 hardwired to zero and write-first bypass.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  localparam logic [AW-1:0] ZeroIdx = AW'(REG_ZERO);

  logic [NREGS-1:1]            wr_en;
  logic [NREGS-1:0][WIDTH-1:0] word;
  logic                        wr_live;
  logic                        byp_a;
  logic                        byp_b;

  always_comb begin
    wr_en = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      wr_en[i] = we && (wr_addr == AW'(i));
    end
  end

  assign word[0] = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_word
    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .en    (wr_en[g]),
      .d     (wr_data),
      .q     (word[g])
    );
  end

  // Bypass stays live during reset; the zero index overrides it.
  assign wr_live = we && (wr_addr != ZeroIdx);
  assign byp_a   = wr_live && (rd_addr_a == wr_addr);
  assign byp_b   = wr_live && (rd_addr_b == wr_addr);

  always_comb begin
    rd_data_a = word[rd_addr_a];
    rd_data_b = word[rd_addr_b];
    if (byp_a) rd_data_a = wr_data;
    if (byp_b) rd_data_b = wr_data;
    if (rd_addr_a == ZeroIdx) rd_data_a = '0;
    if (rd_addr_b == ZeroIdx) rd_data_b = '0;
  end

endmodule
